// File: rtl/fp_pkg.sv
// fp_pkg: format constants and FSM state type shared by both ends of the
// fpcvt datapath (linear-to-float converter and float-to-linear expander).
//   8-bit code: [SIGN_BIT] sign, [EXP_LSB +: EXP_W] exponent, [SIG_W-1:0] significand.
package fp_pkg;
  localparam int EXP_W    = 3;
  localparam int SIG_W    = 4;
  localparam int LIN_W    = 12;
  localparam int CODE_W   = 1 + EXP_W + SIG_W;
  localparam int SIGN_BIT = 7;
  localparam int EXP_LSB  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/fp_expand.sv
// fp_expand: expands an 8-bit compressed float code into a LIN_W-bit two's
// complement value d = +/-(significand << exponent), one shift per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready, f     code input handshake
//   out_valid/out_ready, d   linear result handshake
//   busy                     high whenever a code is in flight (state != IDLE)
module fp_expand #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int SIG_W = fp_pkg::SIG_W,
  parameter int LIN_W = fp_pkg::LIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LIN_W-1:0] d,
  output logic             busy
);
  import fp_pkg::*;

  // Widest magnitude is sig_max << exp_max; with the default format that is
  // 15 << 7 = 1920, which fits in LIN_W-1 bits, so the shift never overflows.
  localparam int MAG_W = SIG_W + (1 << EXP_W) - 1;

  state_t             state, state_nxt;
  logic [MAG_W-1:0]   mag;
  logic [EXP_W-1:0]   cnt;
  logic               sgn;
  logic [LIN_W-1:0]   mag_ext;

  assign mag_ext  = LIN_W'(mag);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)        state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      d         <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          mag <= MAG_W'(f[SIG_W-1:0]);
          cnt <= f[EXP_LSB +: EXP_W];
          sgn <= f[SIGN_BIT];
        end
        SHIFT: begin
          if (cnt != '0) begin
            mag <= mag << 1;
            cnt <= cnt - 1'b1;
          end else begin
            // A zero significand negates to zero, so -0 needs no special case.
            d         <= sgn ? -mag_ext : mag_ext;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_expand.sv
module tb_fp_expand;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d;
  logic        busy;

  int passed = 0;
  int total  = 0;

  fp_expand dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .f(f),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: value = (-1)^sign * significand * 2^exponent, as 12-bit two's complement.
  function automatic logic [11:0] ref_d(input logic [7:0] c);
    int m;
    m = int'(c[3:0]) * (2 ** int'(c[6:4]));
    if (c[7]) m = -m;
    return m[11:0];
  endfunction

  // Push one code, time the result, stall the consumer, then take it.
  task automatic run_code(input logic [7:0] code, input logic [11:0] exp_d,
                          input int exp_lat, input int stall, input string tag);
    int    cyc;
    logic [11:0] dh;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    f = code; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; f = 8'($urandom);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " d"}, 32'(d), 32'(exp_d));
    dh = d;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);   // ignored outside IDLE
      f = 8'($urandom);
      @(negedge clk);
      chk({tag, " stall hold"}, {d, 3'b0, out_valid, 3'b0, in_ready, 3'b0, busy},
          {dh, 4'h1, 4'h0, 4'h1});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " post handshake"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [7:0] c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; f = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset state", {d, 1'b0, out_valid, in_ready, busy}, {12'h000, 4'b0010});

    // Directed cases
    run_code(8'h5D, 12'd416, 6, 0, "5D");
    run_code(8'hFF, 12'h880, 8, 0, "FF");
    run_code(8'h05, 12'd5,   1, 0, "05");
    run_code(8'h80, 12'd0,   1, 0, "80");
    run_code(8'h2B, ref_d(8'h2B), 3, 5, "2B stall5");

    // Reset two cycles into SHIFT discards the pending result
    @(negedge clk);
    f = 8'h7F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-shift reset", {d, 1'b0, out_valid, in_ready, busy}, {12'h000, 4'b0010});
    run_code(8'h13, 12'd6, 2, 0, "13 after reset");

    // Full sweep, random consumer stalls
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      run_code(c, ref_d(c), int'(c[6:4]) + 1, int'($urandom_range(0, 3)), "sweep");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
